// File: rtl/bram_mem_responder.sv
// bram_mem_responder
// Behavioural stand-in for a 16-bit external memory (SDRAM-like).
// Storage is 2^AW x 16 bits, held in a block RAM.
// Command interface:
//   - read, write and refresh are one-cycle pulses, accepted only while idle.
//   - busy and enabled follow a five-state controller.
// Error handling: a sticky fail flag records any command that arrives
// while busy, and any edge on which two or more commands are high.
module bram_mem_responder #(
  parameter int FREQ        = 108_000_000,
  parameter int AW          = 16,
  parameter int INIT_CYCLES = 16,
  parameter int RD_LAT      = 4,
  parameter int WR_LAT      = 4,
  parameter int REF_LAT     = 6
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        read,
  input  logic        write,
  input  logic        refresh,
  input  logic [21:0] addr,
  input  logic [15:0] din,
  input  logic [1:0]  wdm,
  output logic [15:0] dout,
  output logic        busy,
  output logic        fail,
  output logic [23:0] total_written,
  output logic        enabled
);

  localparam int MAX_A   = (INIT_CYCLES > RD_LAT) ? INIT_CYCLES : RD_LAT;
  localparam int MAX_B   = (WR_LAT > REF_LAT) ? WR_LAT : REF_LAT;
  localparam int MAX_LAT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(MAX_LAT + 1);

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    READ,
    WRITE,
    REFRESH
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   addr_q;
  logic [15:0]     din_q;
  logic [1:0]      wdm_q;
  logic [15:0]     rd_q;
  logic [15:0]     mem [2**AW];

  logic            any_cmd;
  logic            multi_cmd;
  logic            accept;
  logic            cmd_err;
  logic            mem_we;
  logic            dout_ld;

  // Upper address bits alias onto the implemented range; FREQ is informational.
  logic            unused_bits;
  assign unused_bits = ^{addr[21:AW], 32'(FREQ)};

  assign any_cmd   = read | write | refresh;
  assign multi_cmd = (read & write) | (read & refresh) | (write & refresh);

  // Next-state, phase counter and per-cycle strobes of the controller.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    accept  = 1'b0;
    cmd_err = 1'b0;
    mem_we  = 1'b0;
    dout_ld = 1'b0;
    busy    = (state_q != IDLE);
    enabled = (state_q != INIT);

    unique case (state_q)
      INIT: begin
        cmd_err = any_cmd;
        if (cnt_q == CW'(INIT_CYCLES - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      IDLE: begin
        cnt_d = '0;
        if (multi_cmd) begin
          cmd_err = 1'b1;
        end else if (read) begin
          state_d = READ;
          accept  = 1'b1;
        end else if (write) begin
          state_d = WRITE;
          accept  = 1'b1;
        end else if (refresh) begin
          state_d = REFRESH;
          accept  = 1'b1;
        end
      end
      READ: begin
        cmd_err = any_cmd;
        if (cnt_q == CW'(RD_LAT - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          dout_ld = 1'b1;
        end
      end
      WRITE: begin
        cmd_err = any_cmd;
        // The array is updated on the first edge after acceptance.
        mem_we  = (cnt_q == '0);
        if (cnt_q == CW'(WR_LAT - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      REFRESH: begin
        cmd_err = any_cmd;
        if (cnt_q == CW'(REF_LAT - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Controller state register; reset restarts initialization and aborts any command.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Command capture, read data output, write counter and sticky error flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q        <= '0;
      din_q         <= '0;
      wdm_q         <= '0;
      dout          <= '0;
      total_written <= '0;
      fail          <= 1'b0;
    end else begin
      if (cmd_err) begin
        fail <= 1'b1;
      end
      if (accept) begin
        addr_q <= addr[AW-1:0];
        din_q  <= din;
        wdm_q  <= wdm;
        if (write) begin
          total_written <= total_written + 24'd1;
        end
      end
      if (dout_ld) begin
        dout <= rd_q;
      end
    end
  end

  // Block RAM port.
  // Byte-masked write; a set wdm bit protects its byte.
  // Synchronous read of the captured address, sampled into dout on the last read cycle.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; contents survive resetn and it maps onto block RAM.
    if (mem_we) begin
      if (!wdm_q[0]) mem[addr_q][7:0]  <= din_q[7:0];
      if (!wdm_q[1]) mem[addr_q][15:8] <= din_q[15:8];
    end
    rd_q <= mem[addr_q];
  end

endmodule
